stub_assembler: RTL and testbench

STUB_ASSEMBLER -- requirements
Module: stub_assembler

---
 rtl/pca_fit_pkg.sv | 37 +++
 rtl/track_fifo.sv | 71 +++++++
 rtl/stub_assembler.sv | 189 ++++++++++++++++++
 tb/tb_stub_assembler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pca_fit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pca_fit_pkg
// Description : Shared types and constants for the track-candidate pipeline.
//               Holds the coordinate width, the stub record (x/y/z) and the
//               default-size track record (TRACK_LAYERS stubs).
// Revision    : 1.0 - initial release
// ============================================================================
package pca_fit_pkg;

    localparam int COORD_W      = 8;
    localparam int TRACK_LAYERS = 6;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } stub_t;

    // Layer k occupies element k (element 0 in the least significant bits).
    typedef stub_t [TRACK_LAYERS-1:0] track_t;

    localparam int STUB_W  = $bits(stub_t);
    localparam int TRACK_W = $bits(track_t);

    function automatic stub_t make_stub(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input logic [COORD_W-1:0] z);
        stub_t s;
        s.x = x;
        s.y = y;
        s.z = z;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/track_fifo.sv
`default_nettype none
// ============================================================================
// Module      : track_fifo
// Description : Synchronous FIFO of complete tracks. Pointers carry one extra
//               wrap bit so full/empty come straight from pointer compare.
//               A push while full is accepted only if a pop happens on the
//               same edge; otherwise it is ignored (caller counts the drop).
//               pop_data reads as zero while the FIFO is empty.
// Ports       : clock, reset (sync, active-high)
//               push, push_data  - write request / track to store
//               full             - all DEPTH entries occupied
//               pop              - remove head (ignored when empty)
//               empty, pop_data  - FIFO empty flag / head track
// Revision    : 1.0 - initial release
// ============================================================================
module track_fifo
    import pca_fit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = TRACK_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !w_empty;
    // A pop on the same edge frees the slot the push needs.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign pop_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/stub_assembler.sv
`default_nettype none
// ============================================================================
// Module      : stub_assembler
// Description : Collects NLAYERS consecutive valid stubs into one track
//               candidate and queues completed tracks in a DEPTH-entry FIFO
//               for a downstream fitter. Upstream has no backpressure; tracks
//               arriving at a full FIFO are dropped and counted.
//               Optional macro STUB_ASSEMBLER_TIMEOUT_EN compiles in a
//               partial-track timeout (TIMEOUT idle cycles -> discard and
//               one-cycle timeout_err pulse). Without it timeout_err is 0.
// Ports       : clock, reset (sync, active-high)
//               data_valid, data_in_x/y/z - incoming stub
//               trk_valid, trk_ready      - output track handshake
//               trk_x/y/z                 - head track, layer k in [8k+7:8k]
//               ovf_cnt                   - saturating dropped-track count
//               timeout_err               - partial-track discard pulse
// Revision    : 1.0 - initial release
// ============================================================================
module stub_assembler
    import pca_fit_pkg::*;
#(
    parameter int NLAYERS = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       data_valid,
    input  logic [COORD_W-1:0]         data_in_x,
    input  logic [COORD_W-1:0]         data_in_y,
    input  logic [COORD_W-1:0]         data_in_z,
    output logic                       trk_valid,
    input  logic                       trk_ready,
    output logic [NLAYERS*COORD_W-1:0] trk_x,
    output logic [NLAYERS*COORD_W-1:0] trk_y,
    output logic [NLAYERS*COORD_W-1:0] trk_z,
    output logic [7:0]                 ovf_cnt,
    output logic                       timeout_err
);

    localparam int CNT_W = (NLAYERS > 1) ? $clog2(NLAYERS) : 1;
    localparam int TRK_W = NLAYERS * STUB_W;

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_COLLECT = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NLAYERS - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;
    logic [CNT_W-1:0]      r_layer_cnt;
    stub_t [NLAYERS-1:0]   r_asm;
    stub_t [NLAYERS-1:0]   w_track;
    stub_t [NLAYERS-1:0]   w_head;
    stub_t                 w_stub;
    logic [7:0]            r_ovf_cnt;

    logic w_last;
    logic w_timeout;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_full;
    logic w_empty;

    assign w_stub = make_stub(data_in_x, data_in_y, data_in_z);
    assign w_last = data_valid && (r_layer_cnt == LAST_CNT);

    // ------------------------------------------------------------------
    // Optional partial-track timeout
    // ------------------------------------------------------------------
`ifdef STUB_ASSEMBLER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_timeout_err;

    // Fires on the TIMEOUT-th consecutive empty cycle inside a track.
    assign w_timeout = (r_state == S_COLLECT) && !data_valid &&
                       (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state == S_COLLECT) && !data_valid && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // w_last already true here when NLAYERS == 1.
                if (data_valid && !w_last) w_next_state = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_last || w_timeout) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs toward the FIFO and the overflow counter
    // ------------------------------------------------------------------
    always_comb begin
        w_push = w_last;
        w_pop  = trk_ready && !w_empty;
        w_drop = w_last && w_full && !w_pop;
    end

    // Completed track = stored layers plus the stub arriving this cycle.
    always_comb begin
        w_track            = r_asm;
        w_track[NLAYERS-1] = w_stub;
    end

    // Assembly buffer and layer count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_layer_cnt <= '0;
            r_asm       <= '0;
        end else if (w_timeout) begin
            r_layer_cnt <= '0;
        end else if (data_valid) begin
            r_asm[r_layer_cnt] <= w_stub;
            r_layer_cnt        <= w_last ? '0 : r_layer_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    track_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRK_W)
    ) u_track_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_track),
        .full      (w_full),
        .pop       (w_pop),
        .empty     (w_empty),
        .pop_data  (w_head)
    );

    assign trk_valid = !w_empty;
    assign ovf_cnt   = r_ovf_cnt;

    for (genvar k = 0; k < NLAYERS; k++) begin : g_unpack
        assign trk_x[COORD_W*k +: COORD_W] = w_head[k].x;
        assign trk_y[COORD_W*k +: COORD_W] = w_head[k].y;
        assign trk_z[COORD_W*k +: COORD_W] = w_head[k].z;
    end

endmodule
`default_nettype wire

// File: tb/tb_stub_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_stub_assembler
// Description : Scoreboard bench for stub_assembler. Stimulus pushes each
//               expected track into a queue; a negedge monitor pops and
//               compares whenever a track handshake is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stub_assembler;

    localparam int NL = 6;
    localparam int W  = NL * 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         data_valid;
    logic [7:0]   data_in_x, data_in_y, data_in_z;
    logic         trk_valid;
    logic         trk_ready;
    logic [W-1:0] trk_x, trk_y, trk_z;
    logic [7:0]   ovf_cnt;
    logic         timeout_err;

    always #5 clock = ~clock;

    stub_assembler #(
        .NLAYERS (NL),
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_valid  (data_valid),
        .data_in_x   (data_in_x),
        .data_in_y   (data_in_y),
        .data_in_z   (data_in_z),
        .trk_valid   (trk_valid),
        .trk_ready   (trk_ready),
        .trk_x       (trk_x),
        .trk_y       (trk_y),
        .trk_z       (trk_z),
        .ovf_cnt     (ovf_cnt),
        .timeout_err (timeout_err)
    );

    int           checks    = 0;
    int           failures  = 0;
    int           pops      = 0;
    int           to_pulses = 0;
    logic [W-1:0] qx[$], qy[$], qz[$];
    logic         hold = 1'b0;
    logic [W-1:0] hx, hy, hz;
    logic [W-1:0] bx, by, bz;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (timeout_err) to_pulses++;
        if (!reset && trk_valid) begin
            if (hold) begin
                check("hold_x", trk_x, hx);
                check("hold_y", trk_y, hy);
                check("hold_z", trk_z, hz);
            end
            if (trk_ready) begin
                hold = 1'b0;
                if (qx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_track actual=%0h required=none", trk_x);
                end else begin
                    check("trk_x", trk_x, qx.pop_front());
                    check("trk_y", trk_y, qy.pop_front());
                    check("trk_z", trk_z, qz.pop_front());
                    pops++;
                end
            end else begin
                hold = 1'b1;
                hx = trk_x;
                hy = trk_y;
                hz = trk_z;
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        data_valid = 1'b1;
        data_in_x  = x;
        data_in_y  = y;
        data_in_z  = z;
        tick();
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Track with x=base+k, y=base+k+0x40, z=base+k+0x80 for layer k.
    task automatic send_track(input logic [7:0] base, input bit keep, input bit ready_on_last);
        logic [7:0] x;
        for (int k = 0; k < NL; k++) begin
            x = base + 8'(k);
            bx[8*k +: 8] = x;
            by[8*k +: 8] = x + 8'h40;
            bz[8*k +: 8] = x + 8'h80;
        end
        if (keep) begin
            qx.push_back(bx);
            qy.push_back(by);
            qz.push_back(bz);
        end
        for (int k = 0; k < NL; k++) begin
            if (ready_on_last && k == NL - 1) trk_ready = 1'b1;
            send(bx[8*k +: 8], by[8*k +: 8], bz[8*k +: 8]);
        end
        if (ready_on_last) trk_ready = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int i;
        data_valid = 1'b0;
        trk_ready  = 1'b1;
        i = 0;
        while (i < max && (qx.size() != 0 || trk_valid)) begin
            tick();
            i++;
        end
        checks++;
        if (qx.size() != 0 || trk_valid) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", qx.size());
        end
    endtask

    int p0;
    int t0;

    initial begin
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in_x  = '0;
        data_in_y  = '0;
        data_in_z  = '0;
        trk_ready  = 1'b0;
        tick();
        tick();
        check("rst_trk_valid", W'(trk_valid), '0);
        check("rst_ovf_cnt", W'(ovf_cnt), '0);
        check("rst_timeout_err", W'(timeout_err), '0);
        check("rst_trk_x", trk_x, '0);
        reset = 1'b0;
        tick();

        // Basic track: x=1..6, y=11..16, z=21..26
        trk_ready = 1'b1;
        qx.push_back(48'h060504030201);
        qy.push_back(48'h100F0E0D0C0B);
        qz.push_back(48'h1A1918171615);
        for (int k = 1; k <= NL; k++) begin
            check("basic_no_early_valid", W'(trk_valid), '0);
            send(8'(k), 8'(10 + k), 8'(20 + k));
        end
        data_valid = 1'b0;
        check("basic_latency_valid", W'(trk_valid), W'(1));
        check("basic_trk_x", trk_x, 48'h060504030201);
        tick();
        check("basic_one_cycle", W'(trk_valid), '0);

        // Gapped input: 3 idle cycles between stubs 2 and 3
        qx.push_back(48'h060504030201);
        qy.push_back(48'h100F0E0D0C0B);
        qz.push_back(48'h1A1918171615);
        for (int k = 1; k <= NL; k++) begin
            send(8'(k), 8'(10 + k), 8'(20 + k));
            if (k == 2) begin
                idle(3);
                check("gap_no_valid", W'(trk_valid), '0);
            end
        end
        drain(20);
        check("gap_no_timeout", W'(to_pulses), '0);

        // Overflow: 5 tracks with trk_ready low; the 5th is dropped
        trk_ready = 1'b0;
        p0 = pops;
        for (int t = 0; t < 5; t++) send_track(8'(t * 16), t < 4, 1'b0);
        tick();
        check("ovf_cnt_one", W'(ovf_cnt), W'(1));
        check("ovf_head_x", trk_x, 48'h050403020100);
        drain(40);
        check("ovf_pops", W'(pops - p0), W'(4));

        // Full FIFO with simultaneous push and pop
        trk_ready = 1'b0;
        p0 = pops;
        for (int t = 5; t < 9; t++) send_track(8'(t * 16), 1'b1, 1'b0);
        send_track(8'h90, 1'b1, 1'b1);
        tick();
        check("full_pp_ovf", W'(ovf_cnt), W'(1));
        check("full_pp_one_pop", W'(pops - p0), W'(1));
        check("full_pp_head", trk_x, 48'h656463626160);
        drain(40);
        check("full_pp_total", W'(pops - p0), W'(5));

        // Reset mid-track (stub present during reset too)
        trk_ready = 1'b1;
        p0 = pops;
        send(8'hA0, 8'hA1, 8'hA2);
        send(8'hA3, 8'hA4, 8'hA5);
        send(8'hA6, 8'hA7, 8'hA8);
        reset = 1'b1;
        send(8'hEE, 8'hEE, 8'hEE);
        reset      = 1'b0;
        data_valid = 1'b0;
        check("mid_rst_valid", W'(trk_valid), '0);
        check("mid_rst_ovf", W'(ovf_cnt), '0);
        check("mid_rst_trk_x", trk_x, '0);
        send_track(8'hB0, 1'b1, 1'b0);
        drain(20);
        check("mid_rst_pops", W'(pops - p0), W'(1));

`ifdef STUB_ASSEMBLER_TIMEOUT_EN
        // Timeout: 2 stubs then 15 idle cycles
        t0 = to_pulses;
        p0 = pops;
        send(8'hC0, 8'hC1, 8'hC2);
        send(8'hC3, 8'hC4, 8'hC5);
        idle(14);
        check("to_not_yet", W'(to_pulses - t0), '0);
        idle(1);
        check("to_pulse_now", W'(timeout_err), W'(1));
        idle(1);
        check("to_pulse_once", W'(to_pulses - t0), W'(1));
        send_track(8'hD0, 1'b1, 1'b0);
        drain(20);
        check("to_clean_pops", W'(pops - p0), W'(1));
        check("to_total_pulses", W'(to_pulses - t0), W'(1));
`else
        t0 = to_pulses;
        check("no_timeout_feature", W'(t0), '0);
`endif

        check("scoreboard_empty", W'(qx.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
